// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite responder that turns each write or read into one native memory
// request, with one-entry AW/W/AR buffers, a bounded ack wait and read/write arbitration.
module axi_lite_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic              aw_full, w_full, ar_full;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [7:0]        tmo_cnt;
  logic              last_rd;
  logic              grant_wr, grant_rd;
  logic              in_wr, wr_ready, rd_ready;
  logic              aw_hs, w_hs, ar_hs;
  logic              req_ack, req_tmo;

  assign in_wr    = (state_q == WR_REQ) || (state_q == WR_RESP);
  assign wr_ready = aw_full && w_full;
  assign rd_ready = ar_full;

  assign S_AXI_AWREADY = !rst && !aw_full && !in_wr;
  assign S_AXI_WREADY  = !rst && !w_full && !in_wr;
  assign S_AXI_ARREADY = !rst && !ar_full;
  assign S_AXI_BVALID  = !rst && (state_q == WR_RESP);
  assign S_AXI_RVALID  = !rst && (state_q == RD_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // An ack on the last allowed cycle wins over the timeout.
  assign req_ack = mem_req && mem_ack;
  assign req_tmo = mem_req && !mem_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_ready && (!rd_ready || last_rd)) begin
          state_d  = WR_REQ;
          grant_wr = 1'b1;
        end else if (rd_ready) begin
          state_d  = RD_REQ;
          grant_rd = 1'b1;
        end
      end
      WR_REQ:  if (req_ack || req_tmo) state_d = WR_RESP;
      WR_RESP: if (S_AXI_BREADY)       state_d = IDLE;
      RD_REQ:  if (req_ack || req_tmo) state_d = RD_RESP;
      RD_RESP: if (S_AXI_RREADY)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      ar_full     <= 1'b0;
      aw_addr     <= '0;
      ar_addr     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      tmo_cnt     <= '0;
      last_rd     <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      S_AXI_BRESP <= 2'b00;
      S_AXI_RRESP <= 2'b00;
      S_AXI_RDATA <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= S_AXI_ARADDR;
      end

      // The fairness flag only moves when both types actually competed.
      if (wr_ready && rd_ready && (grant_wr || grant_rd)) last_rd <= grant_rd;

      if (grant_wr) begin
        mem_we    <= 1'b1;
        mem_addr  <= aw_addr & WORD_MASK;
        mem_wdata <= w_data;
        mem_wstrb <= w_strb;
        tmo_cnt   <= '0;
      end
      if (grant_rd) begin
        mem_we    <= 1'b0;
        mem_addr  <= ar_addr & WORD_MASK;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        tmo_cnt   <= '0;
      end

      if ((state_q == WR_REQ) || (state_q == RD_REQ)) begin
        if (!mem_req) begin
          mem_req <= 1'b1;
        end else if (req_ack) begin
          mem_req <= 1'b0;
          if (state_q == WR_REQ) begin
            S_AXI_BRESP <= mem_err ? 2'b10 : 2'b00;
          end else begin
            S_AXI_RRESP <= mem_err ? 2'b10 : 2'b00;
            S_AXI_RDATA <= mem_rdata;
          end
        end else if (req_tmo) begin
          mem_req <= 1'b0;
          if (state_q == WR_REQ) begin
            S_AXI_BRESP <= 2'b10;
          end else begin
            S_AXI_RRESP <= 2'b10;
            S_AXI_RDATA <= '0;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end

      if ((state_q == WR_RESP) && S_AXI_BREADY) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if ((state_q == RD_RESP) && S_AXI_RREADY) ar_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Directed bench for axi_lite_mem_bridge: a vector table of single transactions
// plus hand-written sequences for reset, W-before-AW and arbitration.
module tb_axi_lite_mem_bridge;

  localparam int ADDR_W = 32;
  localparam int TMO    = 3;
  localparam int NEVER  = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  axi_lite_mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;        // mem_req cycle index (0-based) carrying the ack, NEVER = none
    bit          err;
    logic [31:0] rdata;
    int          hold;       // cycles the response is back-pressured
    logic [1:0]  exp_resp;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
    int          exp_reqc;
    int          exp_lat;    // cycles from buffers full to BVALID/RVALID
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input bit do_aw, input logic [31:0] awaddr, input bit do_w,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input bit do_ar, input logic [31:0] araddr);
    int n;
    bit aw_go, w_go, ar_go;
    n = 0;
    S_AXI_AWADDR  = awaddr;
    S_AXI_WDATA   = wdata;
    S_AXI_WSTRB   = wstrb;
    S_AXI_ARADDR  = araddr;
    S_AXI_AWVALID = do_aw;
    S_AXI_WVALID  = do_w;
    S_AXI_ARVALID = do_ar;
    while ((S_AXI_AWVALID || S_AXI_WVALID || S_AXI_ARVALID) && n < 20) begin
      aw_go = S_AXI_AWREADY;
      w_go  = S_AXI_WREADY;
      ar_go = S_AXI_ARREADY;
      tick();
      n++;
      if (aw_go) S_AXI_AWVALID = 1'b0;
      if (w_go)  S_AXI_WVALID  = 1'b0;
      if (ar_go) S_AXI_ARVALID = 1'b0;
    end
    check("addr_data_accepted", {29'd0, S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID}, 32'd0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
  endtask

  // Native-side responder: acks on the chosen mem_req cycle, otherwise drives junk read data.
  task automatic serve(input int dly, input bit err, input logic [31:0] rdata,
                       output int lat, output int reqc, output int unstable,
                       output logic [31:0] maddr, output logic we,
                       output logic [3:0] strb, output logic [31:0] wdata);
    lat = 0; reqc = 0; unstable = 0;
    maddr = '0; we = 1'b0; strb = '0; wdata = '0;
    while (!S_AXI_BVALID && !S_AXI_RVALID && lat < 40) begin
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin
          maddr = mem_addr; we = mem_we; strb = mem_wstrb; wdata = mem_wdata;
        end else if (mem_addr !== maddr || mem_we !== we || mem_wstrb !== strb ||
                     mem_wdata !== wdata) begin
          unstable++;
        end
        mem_ack   = (dly != NEVER) && (reqc == dly + 1);
        mem_err   = err;
        mem_rdata = mem_ack ? rdata : ~rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_0BAD;
      end
      tick();
      lat++;
    end
    mem_ack = 1'b0;
    mem_err = 1'b0;
    check("response_within_bound", 32'(S_AXI_BVALID || S_AXI_RVALID), 32'd1);
    check("mem_req_low_at_response", 32'(mem_req), 32'd0);
  endtask

  // Checks the response, back-pressures it with stray acks (which must be ignored), then completes it.
  task automatic respond(input bit wr, input int hold, input logic [1:0] exp_resp,
                         input logic [31:0] exp_rdata, input string tag);
    check($sformatf("%s_resp", tag), wr ? 32'(S_AXI_BRESP) : 32'(S_AXI_RRESP), 32'(exp_resp));
    if (!wr) check($sformatf("%s_rdata", tag), S_AXI_RDATA, exp_rdata);
    for (int k = 0; k < hold; k++) begin
      mem_ack   = 1'b1;
      mem_err   = 1'b0;
      mem_rdata = 32'h0;
      tick();
      check($sformatf("%s_valid_held%0d", tag, k), wr ? 32'(S_AXI_BVALID) : 32'(S_AXI_RVALID), 32'd1);
      check($sformatf("%s_resp_held%0d", tag, k), wr ? 32'(S_AXI_BRESP) : 32'(S_AXI_RRESP), 32'(exp_resp));
      if (!wr) check($sformatf("%s_rdata_held%0d", tag, k), S_AXI_RDATA, exp_rdata);
    end
    mem_ack = 1'b0;
    if (wr) S_AXI_BREADY = 1'b1;
    else    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    check($sformatf("%s_valid_dropped", tag), wr ? 32'(S_AXI_BVALID) : 32'(S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    vec_t        v;
    int          lat, reqc, unst;
    logic [31:0] maddr, wdata;
    logic        we;
    logic [3:0]  strb;
    string       tag;

    rst = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;

    vecs[0] = '{wr:1, addr:32'h104, wdata:32'hDEAD_BEEF, wstrb:4'hF, dly:0, err:0, rdata:32'h0,
                hold:0, exp_resp:2'b00, exp_maddr:32'h104, exp_rdata:32'h0, exp_reqc:1, exp_lat:3};
    vecs[1] = '{wr:1, addr:32'h107, wdata:32'h1234_5678, wstrb:4'h5, dly:1, err:1, rdata:32'h0,
                hold:0, exp_resp:2'b10, exp_maddr:32'h104, exp_rdata:32'h0, exp_reqc:2, exp_lat:4};
    vecs[2] = '{wr:0, addr:32'h20, wdata:32'h0, wstrb:4'h0, dly:0, err:1, rdata:32'h0000_CAFE,
                hold:4, exp_resp:2'b10, exp_maddr:32'h20, exp_rdata:32'h0000_CAFE, exp_reqc:1, exp_lat:3};
    vecs[3] = '{wr:0, addr:32'h40, wdata:32'h0, wstrb:4'h0, dly:NEVER, err:0, rdata:32'h1234,
                hold:0, exp_resp:2'b10, exp_maddr:32'h40, exp_rdata:32'h0, exp_reqc:3, exp_lat:5};
    vecs[4] = '{wr:0, addr:32'h33, wdata:32'h0, wstrb:4'h0, dly:2, err:0, rdata:32'hA5A5_5A5A,
                hold:0, exp_resp:2'b00, exp_maddr:32'h30, exp_rdata:32'hA5A5_5A5A, exp_reqc:3, exp_lat:5};
    vecs[5] = '{wr:1, addr:32'hFFFF_FFFE, wdata:32'h0, wstrb:4'h8, dly:NEVER, err:0, rdata:32'h0,
                hold:0, exp_resp:2'b10, exp_maddr:32'hFFFF_FFFC, exp_rdata:32'h0, exp_reqc:3, exp_lat:5};
    vecs[6] = '{wr:0, addr:32'h1000, wdata:32'h0, wstrb:4'h0, dly:1, err:0, rdata:32'hFFFF_FFFF,
                hold:1, exp_resp:2'b00, exp_maddr:32'h1000, exp_rdata:32'hFFFF_FFFF, exp_reqc:2, exp_lat:4};

    // Reset values, then readiness right after release.
    tick();
    tick();
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

    for (int i = 0; i < 7; i++) begin
      v   = vecs[i];
      tag = $sformatf("v%0d", i);
      if (v.wr) send(1'b1, v.addr, 1'b1, v.wdata, v.wstrb, 1'b0, 32'h0);
      else      send(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, v.addr);
      serve(v.dly, v.err, v.rdata, lat, reqc, unst, maddr, we, strb, wdata);
      check($sformatf("%s_latency", tag), 32'(lat), 32'(v.exp_lat));
      check($sformatf("%s_req_cycles", tag), 32'(reqc), 32'(v.exp_reqc));
      check($sformatf("%s_req_stable", tag), 32'(unst), 32'd0);
      check($sformatf("%s_mem_addr", tag), maddr, v.exp_maddr);
      check($sformatf("%s_mem_we", tag), 32'(we), 32'(v.wr));
      check($sformatf("%s_mem_wstrb", tag), 32'(strb), v.wr ? 32'(v.wstrb) : 32'd0);
      if (v.wr) check($sformatf("%s_mem_wdata", tag), wdata, v.wdata);
      respond(v.wr, v.hold, v.exp_resp, v.exp_rdata, tag);
    end

    // W arrives first, AW five cycles later: nothing may be issued until both are held.
    send(1'b0, 32'h0, 1'b1, 32'h1122_3344, 4'h3, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("w_first_no_req%0d", k), 32'(mem_req), 32'd0);
      check($sformatf("w_first_wready_low%0d", k), 32'(S_AXI_WREADY), 32'd0);
      tick();
    end
    send(1'b1, 32'h8, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    serve(0, 1'b0, 32'h0, lat, reqc, unst, maddr, we, strb, wdata);
    check("w_first_req_cycles", 32'(reqc), 32'd1);
    check("w_first_mem_addr", maddr, 32'h8);
    check("w_first_mem_wstrb", 32'(strb), 32'h3);
    check("w_first_mem_wdata", wdata, 32'h1122_3344);
    respond(1'b1, 0, 2'b00, 32'h0, "w_first");

    // Arbitration: first conflict after reset goes to the write, the next one to the read.
    do_reset();
    send(1'b1, 32'h200, 1'b1, 32'h0000_000A, 4'hF, 1'b1, 32'h300);
    check("arb1_arready_full", 32'(S_AXI_ARREADY), 32'd0);
    serve(0, 1'b0, 32'h0, lat, reqc, unst, maddr, we, strb, wdata);
    check("arb1_first_is_write", 32'(we), 32'd1);
    check("arb1_first_addr", maddr, 32'h200);
    respond(1'b1, 0, 2'b00, 32'h0, "arb1_w");
    serve(0, 1'b0, 32'h0000_0055, lat, reqc, unst, maddr, we, strb, wdata);
    check("arb1_second_is_read", 32'(we), 32'd0);
    check("arb1_second_addr", maddr, 32'h300);
    respond(1'b0, 0, 2'b00, 32'h0000_0055, "arb1_r");
    send(1'b1, 32'h204, 1'b1, 32'h0000_000B, 4'hF, 1'b1, 32'h304);
    serve(0, 1'b0, 32'h0000_0066, lat, reqc, unst, maddr, we, strb, wdata);
    check("arb2_first_is_read", 32'(we), 32'd0);
    check("arb2_first_addr", maddr, 32'h304);
    respond(1'b0, 0, 2'b00, 32'h0000_0066, "arb2_r");
    serve(0, 1'b0, 32'h0, lat, reqc, unst, maddr, we, strb, wdata);
    check("arb2_second_is_write", 32'(we), 32'd1);
    check("arb2_second_addr", maddr, 32'h204);
    respond(1'b1, 0, 2'b00, 32'h0, "arb2_w");

    // Reset while a read request is outstanding: abandoned, no response.
    send(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h80);
    for (int k = 0; k < 10 && !mem_req; k++) tick();
    check("mid_rst_req_seen", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_req_dropped", 32'(mem_req), 32'd0);
    check("mid_rst_arready_low", 32'(S_AXI_ARREADY), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_arready_back", 32'(S_AXI_ARREADY), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mid_rst_no_rvalid%0d", k), 32'(S_AXI_RVALID), 32'd0);
      check($sformatf("mid_rst_no_req%0d", k), 32'(mem_req), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
